// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment driver for a BCD adder result.
// Units slot shows the captured sum, tens slot shows the carry.
module bcd_display_scan #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] sum,
  input  logic       carry,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int unsigned CW =
    (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_ONE   = 7'b0110000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  logic [CW-1:0] cnt;
  logic          sel;
  logic [3:0]    cap_sum;
  logic          cap_carry;
  logic          wrap;
  logic [6:0]    units_seg;
  logic [6:0]    tens_seg;
  logic          bad_digit;

  assign wrap = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_sum   <= 4'd0;
      cap_carry <= 1'b0;
    end else if (load) begin
      cap_sum   <= sum;
      cap_carry <= carry;
    end
  end

  always_comb begin
    units_seg = SEG_E;
    bad_digit = 1'b0;
    unique case (cap_sum)
      4'd0:    units_seg = 7'b1111110;
      4'd1:    units_seg = 7'b0110000;
      4'd2:    units_seg = 7'b1101101;
      4'd3:    units_seg = 7'b1111001;
      4'd4:    units_seg = 7'b0110011;
      4'd5:    units_seg = 7'b1011011;
      4'd6:    units_seg = 7'b1011111;
      4'd7:    units_seg = 7'b1110000;
      4'd8:    units_seg = 7'b1111111;
      4'd9:    units_seg = 7'b1111011;
      default: begin
        units_seg = SEG_E;
        bad_digit = 1'b1;
      end
    endcase
  end

  // leading zero is blanked but its digit enable stays on
  assign tens_seg = cap_carry ? SEG_ONE : SEG_BLANK;

  always_comb begin
    seg = units_seg;
    an  = 2'b01;
    unique case (1'b1)
      sel: begin
        seg = tens_seg;
        an  = 2'b10;
      end
      default: begin
        seg = units_seg;
        an  = 2'b01;
      end
    endcase
  end

  assign err = bad_digit;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with a 4-cycle slot.
// Expected {seg,an,err} vectors are queued per edge, popped after it.
module tb_bcd_display_scan;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] sum = 4'd0;
  logic       carry = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int total = 0;
  int bad = 0;

  logic [9:0] q[$];
  int         m_cnt = 0;
  bit         m_sel = 1'b0;
  logic [3:0] m_sum = 4'd0;
  bit         m_carry = 1'b0;

  bcd_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .sum  (sum),
    .carry(carry),
    .seg  (seg),
    .an   (an),
    .err  (err)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] units(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1111110;
      4'd1: return 7'b0110000;
      4'd2: return 7'b1101101;
      4'd3: return 7'b1111001;
      4'd4: return 7'b0110011;
      4'd5: return 7'b1011011;
      4'd6: return 7'b1011111;
      4'd7: return 7'b1110000;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1111011;
      default: return 7'b1001111;
    endcase
  endfunction

  function automatic logic [9:0] expv();
    logic e;
    e = (m_sum > 4'd9);
    if (!m_sel)
      return {units(m_sum), 2'b01, e};
    return {(m_carry ? 7'b0110000 : 7'b0000000), 2'b10, e};
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_sel = 1'b0;
    m_sum = 4'd0;
    m_carry = 1'b0;
    q.delete();
  endtask

  task automatic tick(input bit ld, input logic [3:0] s,
                      input bit c);
    @(negedge clk);
    load = ld;
    sum = s;
    carry = c;
    if (ld) begin
      m_sum = s;
      m_carry = c;
    end
    if (m_cnt == DIV - 1) begin
      m_cnt = 0;
      m_sel = !m_sel;
    end else begin
      m_cnt++;
    end
    q.push_back(expv());
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [9:0] e;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2;
      total++;
      if ({seg, an, err} !== 10'b1111110_01_0) begin
        bad++;
        $display("FAIL reset_hold got=%b want=%b",
                 {seg, an, err}, 10'b1111110_01_0);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4 * DIV; i++) begin
      tick(1'b0, 4'd3, 1'b1);
      e = q.pop_front();
      total++;
      if ({seg, an, err} !== e) begin
        bad++;
        $display("FAIL idle_scan[%0d] got=%b want=%b",
                 i, {seg, an, err}, e);
      end
    end
  endtask

  task automatic test_load_once(input logic [3:0] s,
                                input bit c);
    logic [9:0] e;
    tick(1'b1, s, c);
    e = q.pop_front();
    total++;
    if ({seg, an, err} !== e) begin
      bad++;
      $display("FAIL load_%0d_%0d first got=%b want=%b",
               s, c, {seg, an, err}, e);
    end
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      tick(1'b0, ~s, ~c);
      e = q.pop_front();
      total++;
      if ({seg, an, err} !== e) begin
        bad++;
        $display("FAIL load_%0d_%0d hold[%0d] got=%b want=%b",
                 s, c, i, {seg, an, err}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 4'(i), i[0]);
      e = q.pop_front();
      total++;
      if ({seg, an, err} !== e) begin
        bad++;
        $display("FAIL b2b[%0d] got=%b want=%b",
                 i, {seg, an, err}, e);
      end
    end
    for (int i = 0; i < DIV; i++) begin
      tick(1'b0, 4'd0, 1'b0);
      e = q.pop_front();
      total++;
      if ({seg, an, err} !== e) begin
        bad++;
        $display("FAIL b2b_tail[%0d] got=%b want=%b",
                 i, {seg, an, err}, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    int guard;
    tick(1'b1, 4'd7, 1'b1);
    e = q.pop_front();
    guard = 0;
    while (!(m_sel && m_cnt == 1) && guard < 4 * DIV) begin
      tick(1'b0, 4'd0, 1'b0);
      e = q.pop_front();
      guard++;
    end
    total++;
    if (guard >= 4 * DIV || {seg, an, err} !== e) begin
      bad++;
      $display("FAIL mid_tens_pre got=%b want=%b",
               {seg, an, err}, e);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({seg, an, err} !== 10'b1111110_01_0) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b",
               {seg, an, err}, 10'b1111110_01_0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2 * DIV + 1; i++) begin
      tick(1'b0, 4'd0, 1'b0);
      e = q.pop_front();
      total++;
      if ({seg, an, err} !== e) begin
        bad++;
        $display("FAIL post_reset[%0d] got=%b want=%b",
                 i, {seg, an, err}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_once(4'd5, 1'b1);
    test_load_once(4'd9, 1'b1);
    test_load_once(4'd12, 1'b0);
    test_back_to_back();
    test_load_once(4'd15, 1'b1);
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 Parameter REFRESH_DIV, default 50000, SHALL set the clock cycles per digit slot; legal range 2..2^20; the bench uses 4.
REQ-003 Port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port load, input, 1 bit: capture strobe for sum/carry.
REQ-006 Port sum, input, 4 bits: BCD units digit from the upstream BCD adder.
REQ-007 Port carry, input, 1 bit: decimal carry (tens digit) from the upstream BCD adder.
REQ-008 Port seg, output, 7 bits: segments, active-high; seg[6]=a down to seg[0]=g.
REQ-009 Port an, output, 2 bits: digit enables, one-hot, active-high; an[0]=units, an[1]=tens.
REQ-010 Port err, output, 1 bit: the captured sum is not a valid BCD digit.

Function
REQ-011 Capture: on a rising edge with load=1, cap_sum <= sum and cap_carry <= carry; with load=0, both hold.
REQ-012 Load held high SHALL recapture on every edge; capture latency SHALL be 1 cycle (new value drives seg/err after that edge).
REQ-013 Refresh counter cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; sel SHALL toggle on the edge where cnt wraps.
REQ-014 A slot SHALL last exactly REFRESH_DIV cycles; a full scan SHALL last 2*REFRESH_DIV cycles.
REQ-015 load SHALL NOT affect cnt or sel; a capture during a slot SHALL change seg within that slot.
REQ-016 sel=0: an=01, seg=decode(cap_sum); sel=1: an=10, seg=tens pattern.
REQ-017 Units decode (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
REQ-018 cap_sum 10..15 SHALL drive units seg=1001111 ("E") and err=1; otherwise err=0.
REQ-019 Tens pattern: cap_carry=1 gives 0110000 ("1"); cap_carry=0 gives 0000000 (leading-zero blank, an[1] still asserted).
REQ-020 seg, an and err SHALL be functions of registered state only, with no combinational path from sum, carry or load.
REQ-021 an SHALL always be exactly one-hot, with never both or neither bit set.

Reset
REQ-022 rst_n=0 SHALL immediately, without a clock, force cnt=0, sel=0, cap_sum=0 and cap_carry=0.
REQ-023 During reset, outputs SHALL be seg=1111110, an=01, err=0.
REQ-024 Reset asserted mid-slot or mid-capture SHALL discard in-progress state.
REQ-025 After rst_n rises, the first slot (units) SHALL last a full REFRESH_DIV cycles.

Verification (REFRESH_DIV=4)
REQ-026 Reset, no load: seg=1111110 and an=01 for 4 cycles, then seg=0000000 and an=10 for 4 cycles, repeating; err=0 throughout.
REQ-027 One-cycle load with sum=5, carry=1: next cycle units seg=1011011; tens slot seg=0110000; values hold after load drops.
REQ-028 One-cycle load with sum=9, carry=1 (9+9+1=19): units seg=1111011, tens seg=0110000, err=0.
REQ-029 One-cycle load with sum=12, carry=0: err=1 from the next cycle, units seg=1001111, tens blank.
REQ-030 Load held 10 cycles with sum stepping 0..9 each cycle: the units seg tracks with 1-cycle lag, and the an period stays exactly 4 cycles.
REQ-031 rst_n pulsed low mid tens slot after capturing 7/1: immediate an=01 and seg=1111110; the units slot is 4 full cycles after release.
